// File: rtl/branch_predictor_fetch.sv
// -----------------------------------------------------------------------------
// branch_predictor_fetch
//
// Fetch-side branch predictor. A direct-mapped BTB with 2-bit saturating
// counters gives IF a next-PC guess combinationally. The guess for every fetch
// is held in a pending register until decode resolves that instruction one
// cycle later. A wrong guess raises a one-cycle Mispredict_OUT pulse together
// with the corrected PC. Prediction statistics are also kept here.
//
// Optional feature: define BP_RAS_EN to add a RAS_DEPTH-entry return address
// stack. A BTB hit on a return entry then predicts the stack top when the stack
// is non-empty. Without the macro the stack logic is absent,
// Res_Is_Return_IN / Res_Is_Link_IN are ignored, and return entries predict
// their stored BTB target.
//
// Ports:
//   CLK, RESET (async, active-low), FREEZE_IN (holds all state)
//   Fetch_PC_IN / Fetch_Valid_IN         : fetch-side lookup request
//   Pred_Hit_OUT / Pred_Taken_OUT /
//   Pred_Target_OUT                      : combinational prediction
//   Res_*_IN                             : decode-stage resolution
//   Mispredict_OUT / Correct_PC_OUT      : registered redirect
//   Stat_Branches_OUT / Stat_Mispredicts_OUT : statistics counters
// -----------------------------------------------------------------------------
module branch_predictor_fetch #(
    parameter int INDEX_BITS = 6,
    parameter int RAS_DEPTH  = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FREEZE_IN,
    input  logic [31:0] Fetch_PC_IN,
    input  logic        Fetch_Valid_IN,
    output logic        Pred_Hit_OUT,
    output logic        Pred_Taken_OUT,
    output logic [31:0] Pred_Target_OUT,
    input  logic        Res_Valid_IN,
    input  logic [31:0] Res_PC_IN,
    input  logic        Res_Is_Branch_IN,
    input  logic        Res_Taken_IN,
    input  logic        Res_Is_Link_IN,
    input  logic        Res_Is_Return_IN,
    input  logic [31:0] Res_Target_IN,
    output logic        Mispredict_OUT,
    output logic [31:0] Correct_PC_OUT,
    output logic [31:0] Stat_Branches_OUT,
    output logic [31:0] Stat_Mispredicts_OUT
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 30 - INDEX_BITS;

    // ------------------------------------------------------------------
    // Index / tag split
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] fetch_idx, res_idx;
    logic [TAG_W-1:0]      fetch_tag, res_tag;

    assign fetch_idx = Fetch_PC_IN[INDEX_BITS+1:2];
    assign fetch_tag = Fetch_PC_IN[31:INDEX_BITS+2];
    assign res_idx   = Res_PC_IN[INDEX_BITS+1:2];
    assign res_tag   = Res_PC_IN[31:INDEX_BITS+2];

    // Instructions are word aligned, so the low PC bits carry no information.
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, Fetch_PC_IN[1:0], Res_PC_IN[1:0]};

    logic update_en;
    assign update_en = Res_Valid_IN && !FREEZE_IN;

    // ------------------------------------------------------------------
    // BTB storage: one register set per entry, exposed as read arrays
    // ------------------------------------------------------------------
    logic             btb_valid  [ENTRIES];
    logic [TAG_W-1:0] btb_tag    [ENTRIES];
    logic [31:0]      btb_target [ENTRIES];
    logic [1:0]       btb_ctr    [ENTRIES];
`ifdef BP_RAS_EN
    logic             btb_ret    [ENTRIES];
`endif

    logic       fetch_hit, res_hit;
    logic [1:0] res_ctr, res_ctr_next;

    assign fetch_hit = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
    assign res_hit   = btb_valid[res_idx]   && (btb_tag[res_idx]   == res_tag);
    assign res_ctr   = btb_ctr[res_idx];

    // Saturating 2-bit counter step for the entry being resolved.
    always_comb begin
        res_ctr_next = res_ctr;
        if (Res_Taken_IN) begin
            if (res_ctr != 2'b11) res_ctr_next = res_ctr + 2'b01;
        end else begin
            if (res_ctr != 2'b00) res_ctr_next = res_ctr - 2'b01;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic             valid_reg;
            logic [TAG_W-1:0] tag_reg;
            logic [31:0]      target_reg;
            logic [1:0]       ctr_reg;
            logic             sel;

            assign sel = update_en && (res_idx == INDEX_BITS'(gi));

            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    ctr_reg    <= 2'b00;
                end else if (sel) begin
                    if (Res_Is_Branch_IN) begin
                        if (!res_hit) begin
                            valid_reg  <= 1'b1;
                            tag_reg    <= res_tag;
                            target_reg <= Res_Target_IN;
                            ctr_reg    <= Res_Taken_IN ? 2'b10 : 2'b01;
                        end else begin
                            ctr_reg <= res_ctr_next;
                            if (Res_Taken_IN) target_reg <= Res_Target_IN;
                        end
                    end else if (res_hit) begin
                        // A non-branch sitting on a matching entry means the
                        // entry was created by an alias; drop it.
                        valid_reg <= 1'b0;
                    end
                end
            end

            assign btb_valid[gi]  = valid_reg;
            assign btb_tag[gi]    = tag_reg;
            assign btb_target[gi] = target_reg;
            assign btb_ctr[gi]    = ctr_reg;

`ifdef BP_RAS_EN
            logic ret_reg;
            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) begin
                    ret_reg <= 1'b0;
                end else if (sel && Res_Is_Branch_IN && !res_hit) begin
                    ret_reg <= Res_Is_Return_IN;
                end
            end
            assign btb_ret[gi] = ret_reg;
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Return address stack (circular; a full push overwrites the oldest)
    // ------------------------------------------------------------------
`ifdef BP_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PTR_W-1:0] ras_ptr_reg, ras_ptr_next, ras_ptr_inc, ras_top_idx, ras_wr_idx;
    logic [CNT_W-1:0] ras_cnt_reg, ras_cnt_next;
    logic             ras_wr_en, ras_push, ras_pop;
    logic [31:0]      ras_stack [RAS_DEPTH];
    logic [31:0]      ras_top, ras_push_val;

    // ras_ptr_reg is the next free slot; the top is the slot just below it.
    assign ras_top_idx  = (ras_ptr_reg == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_ptr_reg - 1'b1;
    assign ras_ptr_inc  = (ras_ptr_reg == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr_reg + 1'b1;
    assign ras_top      = ras_stack[ras_top_idx];
    assign ras_push_val = Res_PC_IN + 32'd8;
    assign ras_push     = update_en && Res_Is_Link_IN && Res_Taken_IN;
    assign ras_pop      = update_en && Res_Is_Return_IN;

    always_comb begin
        ras_ptr_next = ras_ptr_reg;
        ras_cnt_next = ras_cnt_reg;
        ras_wr_en    = 1'b0;
        ras_wr_idx   = ras_ptr_reg;
        if (ras_push && ras_pop && (ras_cnt_reg != '0)) begin
            // Return-and-link: the popped slot is immediately reused.
            ras_wr_en  = 1'b1;
            ras_wr_idx = ras_top_idx;
        end else if (ras_push) begin
            ras_wr_en    = 1'b1;
            ras_ptr_next = ras_ptr_inc;
            if (ras_cnt_reg != CNT_W'(RAS_DEPTH)) ras_cnt_next = ras_cnt_reg + 1'b1;
        end else if (ras_pop && (ras_cnt_reg != '0)) begin
            ras_ptr_next = ras_top_idx;
            ras_cnt_next = ras_cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ras_ptr_reg <= '0;
            ras_cnt_reg <= '0;
        end else begin
            ras_ptr_reg <= ras_ptr_next;
            ras_cnt_reg <= ras_cnt_next;
        end
    end

    generate
        for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
            logic [31:0] slot_reg;
            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) begin
                    slot_reg <= '0;
                end else if (ras_wr_en && (ras_wr_idx == PTR_W'(gi))) begin
                    slot_reg <= ras_push_val;
                end
            end
            assign ras_stack[gi] = slot_reg;
        end
    endgenerate
`else
    logic unused_ras_inputs;
    assign unused_ras_inputs = &{1'b0, Res_Is_Link_IN, Res_Is_Return_IN};
`endif

    // ------------------------------------------------------------------
    // Combinational prediction (sees pre-update table contents)
    // ------------------------------------------------------------------
    always_comb begin
        Pred_Hit_OUT    = fetch_hit;
        Pred_Taken_OUT  = fetch_hit && btb_ctr[fetch_idx][1];
        Pred_Target_OUT = '0;
        if (fetch_hit) begin
            Pred_Target_OUT = btb_target[fetch_idx];
`ifdef BP_RAS_EN
            if (btb_ret[fetch_idx] && (ras_cnt_reg != '0)) Pred_Target_OUT = ras_top;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Pending prediction, mispredict detection, statistics
    // ------------------------------------------------------------------
    logic [31:0] pend_pc_reg, pend_target_reg;
    logic        pend_taken_reg, pend_valid_reg;
    logic        mispredict_reg, mispredict_next;
    logic [31:0] correct_pc_reg, stat_branches_reg, stat_mispredicts_reg;

    // Only the instruction the pending entry describes is compared; a taken
    // prediction is also wrong when it pointed at the wrong target.
    assign mispredict_next = update_en && pend_valid_reg && (Res_PC_IN == pend_pc_reg) &&
                             ((pend_taken_reg != Res_Taken_IN) ||
                              (pend_taken_reg && Res_Taken_IN && (pend_target_reg != Res_Target_IN)));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pend_pc_reg          <= '0;
            pend_target_reg      <= '0;
            pend_taken_reg       <= 1'b0;
            pend_valid_reg       <= 1'b0;
            mispredict_reg       <= 1'b0;
            correct_pc_reg       <= '0;
            stat_branches_reg    <= '0;
            stat_mispredicts_reg <= '0;
        end else if (FREEZE_IN) begin
            mispredict_reg <= 1'b0;
        end else begin
            pend_pc_reg     <= Fetch_PC_IN;
            pend_target_reg <= Pred_Target_OUT;
            pend_taken_reg  <= Pred_Taken_OUT;
            pend_valid_reg  <= Fetch_Valid_IN;
            mispredict_reg  <= mispredict_next;
            if (mispredict_next) begin
                // Not-taken redirect skips the delay slot.
                correct_pc_reg       <= Res_Taken_IN ? Res_Target_IN : Res_PC_IN + 32'd8;
                stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
            end
            if (Res_Valid_IN && Res_Is_Branch_IN) begin
                stat_branches_reg <= stat_branches_reg + 32'd1;
            end
        end
    end

    assign Mispredict_OUT       = mispredict_reg;
    assign Correct_PC_OUT       = correct_pc_reg;
    assign Stat_Branches_OUT    = stat_branches_reg;
    assign Stat_Mispredicts_OUT = stat_mispredicts_reg;

endmodule

// File: tb/tb_branch_predictor_fetch.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor_fetch
//
// Directed scoreboard bench for branch_predictor_fetch. Stimulus pushes the
// expected lookup result / redirect into queues; a negedge monitor pops and
// compares whenever a lookup is flagged or Mispredict_OUT pulses.
// Expected RAS-dependent targets follow the BP_RAS_EN build macro.
// -----------------------------------------------------------------------------
module tb_branch_predictor_fetch;

`ifdef BP_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic        FREEZE_IN;
    logic [31:0] Fetch_PC_IN;
    logic        Fetch_Valid_IN;
    logic        Pred_Hit_OUT, Pred_Taken_OUT;
    logic [31:0] Pred_Target_OUT;
    logic        Res_Valid_IN;
    logic [31:0] Res_PC_IN;
    logic        Res_Is_Branch_IN, Res_Taken_IN, Res_Is_Link_IN, Res_Is_Return_IN;
    logic [31:0] Res_Target_IN;
    logic        Mispredict_OUT;
    logic [31:0] Correct_PC_OUT, Stat_Branches_OUT, Stat_Mispredicts_OUT;

    branch_predictor_fetch dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .FREEZE_IN           (FREEZE_IN),
        .Fetch_PC_IN         (Fetch_PC_IN),
        .Fetch_Valid_IN      (Fetch_Valid_IN),
        .Pred_Hit_OUT        (Pred_Hit_OUT),
        .Pred_Taken_OUT      (Pred_Taken_OUT),
        .Pred_Target_OUT     (Pred_Target_OUT),
        .Res_Valid_IN        (Res_Valid_IN),
        .Res_PC_IN           (Res_PC_IN),
        .Res_Is_Branch_IN    (Res_Is_Branch_IN),
        .Res_Taken_IN        (Res_Taken_IN),
        .Res_Is_Link_IN      (Res_Is_Link_IN),
        .Res_Is_Return_IN    (Res_Is_Return_IN),
        .Res_Target_IN       (Res_Target_IN),
        .Mispredict_OUT      (Mispredict_OUT),
        .Correct_PC_OUT      (Correct_PC_OUT),
        .Stat_Branches_OUT   (Stat_Branches_OUT),
        .Stat_Mispredicts_OUT(Stat_Mispredicts_OUT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] pc;
    } mp_t;

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic        tk;
        logic [31:0] tg;
        logic [31:0] sb;
        logic [31:0] sm;
    } lk_t;

    mp_t  mp_q[$];
    lk_t  lk_q[$];
    logic chk       = 1'b0;
    logic final_chk = 1'b0;
    int   n_tests   = 0;
    int   n_fail    = 0;

    // ---------------------------------------------------------------- monitor
    always @(negedge CLK) begin
        if (RESET) begin
            if (Mispredict_OUT) begin
                n_tests++;
                if (mp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_mispredict cyc=%0d got pc=%08h required no pulse", cyc, Correct_PC_OUT);
                end else begin
                    mp_t e;
                    e = mp_q.pop_front();
                    if (Correct_PC_OUT !== e.pc || cyc != e.due) begin
                        n_fail++;
                        $display("[TB] FAIL mispredict cyc=%0d got pc=%08h required pc=%08h at cyc=%0d",
                                 cyc, Correct_PC_OUT, e.pc, e.due);
                    end else begin
                        $display("[TB] redirect cyc=%0d pc=%08h ok", cyc, Correct_PC_OUT);
                    end
                end
            end else if (mp_q.size() != 0 && mp_q[0].due <= cyc) begin
                mp_t e;
                e = mp_q.pop_front();
                n_tests++;
                n_fail++;
                $display("[TB] FAIL missing_mispredict cyc=%0d got none required pc=%08h", cyc, e.pc);
            end
            if (chk) begin
                lk_t e;
                n_tests++;
                if (lk_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL lookup_queue cyc=%0d got empty queue required an entry", cyc);
                end else begin
                    e = lk_q.pop_front();
                    if (Pred_Hit_OUT !== e.hit || Pred_Taken_OUT !== e.tk || Pred_Target_OUT !== e.tg ||
                        Stat_Branches_OUT !== e.sb || Stat_Mispredicts_OUT !== e.sm) begin
                        n_fail++;
                        $display("[TB] FAIL lookup pc=%08h got hit=%0b tk=%0b tg=%08h br=%0d mp=%0d required hit=%0b tk=%0b tg=%08h br=%0d mp=%0d",
                                 e.pc, Pred_Hit_OUT, Pred_Taken_OUT, Pred_Target_OUT, Stat_Branches_OUT,
                                 Stat_Mispredicts_OUT, e.hit, e.tk, e.tg, e.sb, e.sm);
                    end else begin
                        $display("[TB] lookup pc=%08h hit=%0b tk=%0b tg=%08h br=%0d mp=%0d ok",
                                 e.pc, e.hit, e.tk, e.tg, e.sb, e.sm);
                    end
                end
            end
            if (final_chk) begin
                n_tests++;
                if (mp_q.size() != 0 || lk_q.size() != 0) begin
                    n_fail++;
                    $display("[TB] FAIL leftover_expectations got mp=%0d lk=%0d required 0 0", mp_q.size(), lk_q.size());
                end
            end
        end
    end

    // ---------------------------------------------------------------- tasks
    task automatic idle();
        FREEZE_IN        = 1'b0;
        Fetch_PC_IN      = '0;
        Fetch_Valid_IN   = 1'b0;
        Res_Valid_IN     = 1'b0;
        Res_PC_IN        = '0;
        Res_Is_Branch_IN = 1'b0;
        Res_Taken_IN     = 1'b0;
        Res_Is_Link_IN   = 1'b0;
        Res_Is_Return_IN = 1'b0;
        Res_Target_IN    = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        idle();
        chk       = 1'b0;
        final_chk = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc, input logic fv);
        Fetch_PC_IN    = pc;
        Fetch_Valid_IN = fv;
    endtask

    task automatic res(input logic [31:0] pc, input logic br, input logic tk,
                       input logic lnk, input logic rt, input logic [31:0] tg);
        Res_Valid_IN     = 1'b1;
        Res_PC_IN        = pc;
        Res_Is_Branch_IN = br;
        Res_Taken_IN     = tk;
        Res_Is_Link_IN   = lnk;
        Res_Is_Return_IN = rt;
        Res_Target_IN    = tg;
    endtask

    task automatic exp_lk(input logic hit, input logic tk, input logic [31:0] tg,
                          input logic [31:0] sb, input logic [31:0] sm);
        lk_t e;
        e.pc = Fetch_PC_IN; e.hit = hit; e.tk = tk; e.tg = tg; e.sb = sb; e.sm = sm;
        lk_q.push_back(e);
        chk = 1'b1;
    endtask

    task automatic exp_mp(input logic [31:0] pc);
        mp_t e;
        e.due = cyc + 1;
        e.pc  = pc;
        mp_q.push_back(e);
    endtask

    localparam logic [31:0] B20 = 32'h00400020;
    localparam logic [31:0] T100 = 32'h00400100;
    localparam logic [31:0] JR = 32'h00400090;
    localparam logic [31:0] RT = 32'h00400700;

    // ---------------------------------------------------------------- stimulus
    initial begin
        idle();
        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;

        // Reset state, miss; pending captures a not-taken guess for B20.
        look(B20, 1'b1); exp_lk(0, 0, 0, 0, 0); tick();
        // Taken resolution -> mispredict to the target, entry allocated ctr=10.
        res(B20, 1, 1, 0, 0, T100); exp_mp(T100); tick();
        look(B20, 1'b0); exp_lk(1, 1, T100, 1, 1); tick();
        // Predicted taken, then a would-be mispredict under FREEZE.
        look(B20, 1'b1); exp_lk(1, 1, T100, 1, 1); tick();
        FREEZE_IN = 1'b1; res(B20, 1, 0, 0, 0, T100); look(B20, 1'b0); exp_lk(1, 1, T100, 1, 1); tick();
        look(B20, 1'b0); exp_lk(1, 1, T100, 1, 1); tick();

        // Counter walk 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10.
        res(B20, 1, 0, 0, 0, T100); tick();
        res(B20, 1, 0, 0, 0, T100); look(B20, 1'b0); exp_lk(1, 0, T100, 2, 1); tick();
        res(B20, 1, 0, 0, 0, T100); look(B20, 1'b0); exp_lk(1, 0, T100, 3, 1); tick();
        res(B20, 1, 1, 0, 0, T100); look(B20, 1'b0); exp_lk(1, 0, T100, 4, 1); tick();
        res(B20, 1, 1, 0, 0, 32'h00400140); look(B20, 1'b0); exp_lk(1, 0, T100, 5, 1); tick();
        res(B20, 1, 1, 0, 0, 32'h00400140); look(B20, 1'b0); exp_lk(1, 1, 32'h00400140, 6, 1); tick();
        res(B20, 1, 1, 0, 0, 32'h00400140); tick();
        res(B20, 1, 0, 0, 0, 32'hDEAD0000); tick();
        look(B20, 1'b0); exp_lk(1, 1, 32'h00400140, 9, 1); tick();

        // Alias at the same index with a different tag, then non-branch cleanup.
        res(32'h00400120, 1, 1, 0, 0, 32'h00400200); tick();
        look(B20, 1'b0); exp_lk(0, 0, 0, 10, 1); tick();
        look(32'h00400120, 1'b0); exp_lk(1, 1, 32'h00400200, 10, 1); res(32'h00400120, 0, 0, 0, 0, 0); tick();
        look(32'h00400120, 1'b0); exp_lk(0, 0, 0, 10, 1); tick();

        // Predicted taken, actually not taken -> redirect to PC+8.
        res(32'h00400040, 1, 1, 0, 0, 32'h00400300); tick();
        look(32'h00400040, 1'b1); exp_lk(1, 1, 32'h00400300, 11, 1); tick();
        res(32'h00400040, 1, 0, 0, 0, 0); exp_mp(32'h00400048); tick();
        look(32'h00400040, 1'b0); exp_lk(1, 0, 32'h00400300, 12, 2); tick();

        // Taken as predicted but to a different target.
        res(32'h00400060, 1, 1, 0, 0, 32'h00400400); tick();
        look(32'h00400060, 1'b1); exp_lk(1, 1, 32'h00400400, 13, 2); tick();
        res(32'h00400060, 1, 1, 0, 0, 32'h00400500); exp_mp(32'h00400500); tick();
        look(32'h00400060, 1'b0); exp_lk(1, 1, 32'h00400500, 14, 3); tick();
        // Correct prediction: no pulse.
        look(32'h00400060, 1'b1); tick();
        res(32'h00400060, 1, 1, 0, 0, 32'h00400500); tick();
        // Resolution for a PC other than the pending one: no compare.
        look(32'h00400040, 1'b1); tick();
        res(32'h00400060, 1, 1, 0, 0, 32'h00400500); tick();
        look(32'h00400060, 1'b0); exp_lk(1, 1, 32'h00400500, 16, 3); tick();

        // Return address stack.
        res(JR, 1, 1, 0, 1, RT); tick();
        res(32'h00400000, 1, 1, 1, 0, 32'h00400080); tick();
        look(JR, 1'b0); exp_lk(1, 1, RAS ? 32'h00400008 : RT, 18, 3); tick();
        for (int k = 0; k < 4; k++) begin
            res(32'h00402010 + 32'(k) * 32'h20, 1, 1, 1, 0, 32'h00400080); tick();
        end
        look(JR, 1'b0); exp_lk(1, 1, RAS ? 32'h00402078 : RT, 22, 3); res(JR, 1, 1, 0, 1, RT); tick();
        look(JR, 1'b0); exp_lk(1, 1, RAS ? 32'h00402058 : RT, 23, 3); res(JR, 1, 1, 0, 1, RT); tick();
        look(JR, 1'b0); exp_lk(1, 1, RAS ? 32'h00402038 : RT, 24, 3); res(JR, 1, 1, 0, 1, RT); tick();
        look(JR, 1'b0); exp_lk(1, 1, RAS ? 32'h00402018 : RT, 25, 3); res(JR, 1, 1, 0, 1, RT); tick();
        // Oldest entry was overwritten: stack now empty, BTB target used.
        look(JR, 1'b0); exp_lk(1, 1, RT, 26, 3); res(JR, 1, 1, 0, 1, RT); tick();
        look(JR, 1'b0); exp_lk(1, 1, RT, 27, 3); res(32'h00402010, 1, 1, 1, 0, 32'h00400080); tick();
        look(JR, 1'b0); exp_lk(1, 1, RAS ? 32'h00402018 : RT, 28, 3); tick();

        // Asynchronous reset mid-run clears table and statistics.
        RESET = 1'b0;
        #13;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        look(JR, 1'b0); exp_lk(0, 0, 0, 0, 0); tick();

        repeat (3) tick();
        final_chk = 1'b1;
        @(posedge CLK);
        #1;
        final_chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
